// File: rtl/dmx_pkg.sv
// dmx_pkg: types and constants shared by the demux3_stream block.
//   dmx_state_t : occupancy of the two-entry buffer (EMPTY / BUSY / FULL)
//   SEL_*       : destination select encodings carried with each word
//   sel_onehot  : maps a legal select to a one-hot consumer vector
package dmx_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } dmx_state_t;

  localparam logic [1:0] SEL_OUT0    = 2'b00;
  localparam logic [1:0] SEL_OUT1    = 2'b01;
  localparam logic [1:0] SEL_OUT2    = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  // Only legal selects ever reach the main entry, so SEL_ILLEGAL is
  // mapped to zero rather than left undefined.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_OUT0: oh = 3'b001;
      SEL_OUT1: oh = 3'b010;
      SEL_OUT2: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dmx_stats.sv
// dmx_stats: per-destination transfer counters plus an illegal-select drop
// counter for demux3_stream. All counters wrap modulo 2^CNT_W.
//   clk, rst_n         : clock, asynchronous active-low reset
//   clr                : synchronous clear of every counter
//   fire[2:0]          : one bit per consumer, high when that consumer transfers
//   drop               : an illegal-select word was accepted and discarded
//   stat_cnt0/1/2      : transfer counts for out0/out1/out2
//   stat_drop          : count of discarded illegal words
module dmx_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [2:0]       fire,
  input  logic             drop,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1,
  output logic [CNT_W-1:0] stat_cnt2,
  output logic [CNT_W-1:0] stat_drop
);

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] drop_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q[gi] <= '0;
        else if (clr)      cnt_q[gi] <= '0;
        else if (fire[gi]) cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    drop_q <= '0;
    else if (clr)  drop_q <= '0;
    else if (drop) drop_q <= drop_q + 1'b1;
  end

  assign stat_cnt0 = cnt_q[0];
  assign stat_cnt1 = cnt_q[1];
  assign stat_cnt2 = cnt_q[2];
  assign stat_drop = drop_q;

endmodule

// File: rtl/demux3_stream.sv
// demux3_stream: one-input, three-output valid/ready router. Each input word
// carries a 2-bit destination select and is presented to exactly one consumer.
// A main entry plus a skid entry give full throughput with a registered
// in_ready. Words leave in strict arrival order across all destinations.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : producer handshake (in_ready is registered)
//   in_data[NB], in_sel : producer word and destination (11 = illegal)
//   out_valid[3]        : one-hot or zero, one bit per consumer
//   out_ready[3]        : per-consumer ready
//   out_data[NB]        : shared data bus, valid where out_valid[i]=1
//   err, err_clr        : sticky illegal-select flag and its synchronous clear
//
// Optional build macro DEMUX3_STATS_EN adds stat_cnt0/1/2 and stat_drop
// (CNT_W bits each) via the dmx_stats counter bank.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module demux3_stream
  import dmx_pkg::*;
#(
  parameter int NB    = `WORD_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NB-1:0]    in_data,
  input  logic [1:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [NB-1:0]    out_data,
  output logic             err,
  input  logic             err_clr
`ifdef DEMUX3_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1,
  output logic [CNT_W-1:0] stat_cnt2,
  output logic [CNT_W-1:0] stat_drop
`endif
);

  dmx_state_t    state_q, state_d;
  logic [NB-1:0] main_data_q, main_data_d;
  logic [NB-1:0] skid_data_q, skid_data_d;
  logic [1:0]    main_sel_q, main_sel_d;
  logic [1:0]    skid_sel_q, skid_sel_d;
  logic          in_ready_q;
  logic          err_q, err_d;

  logic          accept, illegal_acc, legal_acc, drain;
  logic [2:0]    fire;

  assign accept      = in_valid & in_ready_q;
  assign illegal_acc = accept & (in_sel == SEL_ILLEGAL);
  assign legal_acc   = accept & (in_sel != SEL_ILLEGAL);

  // Outputs decode only registered state, so there is no in->out path.
  assign out_valid = (state_q != EMPTY) ? sel_onehot(main_sel_q) : 3'b000;
  assign out_data  = main_data_q;
  assign fire      = out_valid & out_ready;
  assign drain     = |fire;
  assign in_ready  = in_ready_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      EMPTY: begin
        if (legal_acc) begin
          state_d     = BUSY;
          main_data_d = in_data;
          main_sel_d  = in_sel;
        end
      end
      BUSY: begin
        if (legal_acc && !drain) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_sel_d  = in_sel;
        end else if (legal_acc && drain) begin
          main_data_d = in_data;
          main_sel_d  = in_sel;
        end else if (drain) begin
          // Also covers an illegal accept coinciding with a drain: the
          // illegal word is dropped and the head still leaves.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d     = BUSY;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Set wins over clear when an illegal accept meets err_clr.
  always_comb begin
    err_d = err_q;
    if (illegal_acc)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= SEL_OUT0;
      skid_data_q <= '0;
      skid_sel_q  <= SEL_OUT0;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= (state_d != FULL);
      err_q       <= err_d;
    end
  end

`ifdef DEMUX3_STATS_EN
  dmx_stats #(.CNT_W(CNT_W)) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (err_clr),
    .fire      (fire),
    .drop      (illegal_acc),
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_drop (stat_drop)
  );
`endif

`ifndef SYNTHESIS
  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_valid))
    else $error("demux3_stream: out_valid not one-hot or zero: %b", out_valid);
`endif

endmodule

// File: tb/tb_demux3_stream.sv
module tb_demux3_stream;
  localparam int NB    = 32;
  localparam int CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic [1:0]    in_sel;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [NB-1:0] out_data;
  logic          err;
  logic          err_clr;
`ifdef DEMUX3_STATS_EN
  logic [CNT_W-1:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_drop;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pops = 0;

  demux3_stream #(.NB(NB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .err_clr   (err_clr)
`ifdef DEMUX3_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_drop (stat_drop)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a FIFO of at most two words; the head is shown to the
  // consumer its select names; illegal words are dropped and raise err.
  logic [NB-1:0] mq_data[$];
  logic [1:0]    mq_sel[$];
  logic          m_in_ready = 1'b0;
  logic          m_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq_data.delete();
        mq_sel.delete();
        m_in_ready = 1'b0;
        m_err      = 1'b0;
      end else begin
        logic acc;
        acc = in_valid && m_in_ready;
        if (mq_sel.size() > 0 && out_ready[mq_sel[0]]) begin
          void'(mq_data.pop_front());
          void'(mq_sel.pop_front());
          pops++;
        end
        if (acc && in_sel == 2'b11) m_err = 1'b1;
        else if (err_clr)           m_err = 1'b0;
        if (acc && in_sel != 2'b11) begin
          mq_data.push_back(in_data);
          mq_sel.push_back(in_sel);
        end
        m_in_ready = (mq_sel.size() < 2);
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs vs the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [2:0] ev;
        ev = (mq_sel.size() > 0) ? (3'b001 << mq_sel[0]) : 3'b000;
        check("model_out_valid", 64'(out_valid), 64'(ev));
        check("model_in_ready", 64'(in_ready), 64'(m_in_ready));
        check("model_err", 64'(err), 64'(m_err));
        if (mq_sel.size() > 0) check("model_out_data", 64'(out_data), 64'(mq_data[0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [NB-1:0] d, input logic [1:0] s);
    int tries;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    tries    = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) check("send_timeout", 64'(tries), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int t0, p0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'b00;
    out_ready = 3'b000; err_clr = 1'b0;
    idle(3);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("first_edge_in_ready", 64'(in_ready), 64'(1));

    // First accept, 1-cycle latency
    send(32'h0000_00AA, 2'b01);
    $display("txn: AA sel 01 -> out_valid %b data %h", out_valid, out_data);
    check("first_out_valid", 64'(out_valid), 64'(3'b010));
    check("first_out_data", 64'(out_data), 64'h0000_00AA);
    out_ready = 3'b010; idle(1); out_ready = 3'b000;
    check("first_drained", 64'(out_valid), 64'(0));

    // Back-pressure to FULL, then drain in order
    send(32'h11, 2'b00);
    send(32'h22, 2'b10);
    $display("txn: 11/22 backpressured -> in_ready %b out_valid %b", in_ready, out_valid);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_head_valid", 64'(out_valid), 64'(3'b001));
    check("full_head_data", 64'(out_data), 64'h11);
    out_ready = 3'b001; idle(1);
    check("skid_out_valid", 64'(out_valid), 64'(3'b100));
    check("skid_out_data", 64'(out_data), 64'h22);
    check("skid_in_ready", 64'(in_ready), 64'(1));
    out_ready = 3'b100; idle(1); out_ready = 3'b000;

    // Streaming: 8 back-to-back words, all consumers ready
    out_ready = 3'b111;
    t0 = cyc; p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send(NB'(32'h100 + i), 2'(i % 3));
      $display("txn: stream %0d sel %0d out_valid %b data %h", i, i % 3, out_valid, out_data);
    end
    check("stream_cycles", 64'(cyc - t0), 64'(8));
    idle(2);
    check("stream_pops", 64'(pops - p0), 64'(8));
    out_ready = 3'b000;

    // Illegal select while BUSY
    send(32'h33, 2'b00);
    send(32'hDEAD, 2'b11);
    $display("txn: DEAD sel 11 -> err %b out_data %h", err, out_data);
    check("illegal_err", 64'(err), 64'(1));
    check("illegal_head_valid", 64'(out_valid), 64'(3'b001));
    check("illegal_head_data", 64'(out_data), 64'h33);
    check("illegal_in_ready", 64'(in_ready), 64'(1));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("err_cleared", 64'(err), 64'(0));
    err_clr = 1'b1;
    send(32'hBEEF, 2'b11);
    err_clr = 1'b0;
    $display("txn: BEEF sel 11 with err_clr -> err %b", err);
    check("set_wins_err", 64'(err), 64'(1));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    out_ready = 3'b001; idle(1); out_ready = 3'b000;
    check("after_illegal_empty", 64'(out_valid), 64'(0));

    // Asynchronous reset while FULL
    send(32'h44, 2'b00);
    send(32'h55, 2'b01);
    check("pre_reset_full", 64'(in_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    $display("txn: async reset in FULL -> out_valid %b in_ready %b", out_valid, in_ready);
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    out_ready = 3'b111;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("no_stale_after_rst", 64'(out_valid), 64'(0));
    out_ready = 3'b000;

`ifdef DEMUX3_STATS_EN
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    out_ready = 3'b111;
    for (int i = 0; i < 5; i++) send(NB'(32'h200 + i), 2'b10);
    for (int i = 0; i < 2; i++) send(NB'(32'h300 + i), 2'b11);
    for (int i = 0; i < 3; i++) send(NB'(32'h400 + i), 2'b00);
    idle(2);
    $display("txn: stats cnt0 %0d cnt1 %0d cnt2 %0d drop %0d", stat_cnt0, stat_cnt1, stat_cnt2, stat_drop);
    check("stat_cnt2", 64'(stat_cnt2), 64'(5));
    check("stat_drop", 64'(stat_drop), 64'(2));
    check("stat_cnt0", 64'(stat_cnt0), 64'(3));
    check("stat_cnt1", 64'(stat_cnt1), 64'(0));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("stat_cleared", 64'(stat_cnt2), 64'(0));
    out_ready = 3'b000;
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
